// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side, execute-side and status signals of the decode queue
interface decode_queue_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
);
    logic                     f_to_d_valid;
    logic                     d_allow_in;
    logic [DATA_W-1:0]        f_payload;
    logic [31:0]              f_pc;
    logic [4:0]               f_rs1;
    logic [4:0]               f_rs2;
    logic                     f_use_rs1;
    logic                     f_use_rs2;
    logic                     e_allow_in;
    logic                     d_to_e_valid;
    logic [DATA_W-1:0]        D_payload;
    logic [31:0]              D_pc;
    logic [4:0]               D_rs1;
    logic [4:0]               D_rs2;
    logic                     D_commit;
    logic                     e_valid;
    logic                     E_is_load;
    logic [4:0]               E_rd;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;
    logic [15:0]              stall_cnt;

    modport master (
        output f_to_d_valid, f_payload, f_pc, f_rs1, f_rs2, f_use_rs1, f_use_rs2,
        output e_allow_in, e_valid, E_is_load, E_rd, flush,
        input  d_allow_in, d_to_e_valid, D_payload, D_pc, D_rs1, D_rs2, D_commit, count, stall_cnt
    );

    modport slave (
        input  f_to_d_valid, f_payload, f_pc, f_rs1, f_rs2, f_use_rs1, f_use_rs2,
        input  e_allow_in, e_valid, E_is_load, E_rd, flush,
        output d_allow_in, d_to_e_valid, D_payload, D_pc, D_rs1, D_rs2, D_commit, count, stall_cnt
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: decoded-instruction FIFO with load-use hazard gating; define DECODE_QUEUE_BYPASS_EN for an empty-queue bypass
module decode_queue #(
    parameter int          DATA_W    = 64,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] COMMIT_LO = 32'h80000000,
    parameter logic [31:0] COMMIT_HI = 32'h87ffffff
) (
    input logic           clk,
    input logic           rst,
    decode_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_payload [DEPTH];
    logic [31:0]       mem_pc      [DEPTH];
    logic [4:0]        mem_rs1     [DEPTH];
    logic [4:0]        mem_rs2     [DEPTH];
    logic              mem_use1    [DEPTH];
    logic              mem_use2    [DEPTH];
    logic              mem_commit  [DEPTH];

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;
    logic [15:0]       stall;
    logic              empty, byp, head_ok, hazard, enq, deq, f_commit;
    logic [DATA_W-1:0] h_payload;
    logic [31:0]       h_pc;
    logic [4:0]        h_rs1, h_rs2;
    logic              h_use1, h_use2, h_commit;

    assign empty    = cnt == '0;
    assign f_commit = q.f_pc >= COMMIT_LO && q.f_pc <= COMMIT_HI;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign byp = empty && q.f_to_d_valid && !q.flush;
`else
    assign byp = 1'b0;
`endif

    // head entry: stored head, or the incoming fetch entry while bypassing an empty queue
    always_comb begin
        h_payload = byp ? q.f_payload : mem_payload[rd_ptr];
        h_pc      = byp ? q.f_pc      : mem_pc[rd_ptr];
        h_rs1     = byp ? q.f_rs1     : mem_rs1[rd_ptr];
        h_rs2     = byp ? q.f_rs2     : mem_rs2[rd_ptr];
        h_use1    = byp ? q.f_use_rs1 : mem_use1[rd_ptr];
        h_use2    = byp ? q.f_use_rs2 : mem_use2[rd_ptr];
        h_commit  = byp ? f_commit    : mem_commit[rd_ptr];
    end

    assign hazard  = q.e_valid && q.E_is_load && q.E_rd != 5'd0 &&
                     ((h_use1 && q.E_rd == h_rs1) || (h_use2 && q.E_rd == h_rs2));
    assign head_ok = !rst && (!empty || byp);

    assign q.d_to_e_valid = head_ok && !hazard;
    assign q.d_allow_in   = cnt != CW'(DEPTH);
    assign q.D_payload    = head_ok ? h_payload : '0;
    assign q.D_pc         = head_ok ? h_pc : '0;
    assign q.D_rs1        = head_ok ? h_rs1 : '0;
    assign q.D_rs2        = head_ok ? h_rs2 : '0;
    assign q.D_commit     = head_ok && h_commit;
    assign q.count        = cnt;
    assign q.stall_cnt    = stall;

    // an entry that passes straight through the bypass is never stored
    assign enq = q.f_to_d_valid && q.d_allow_in && !q.flush && !(byp && q.e_allow_in && q.d_to_e_valid);
    assign deq = q.d_to_e_valid && q.e_allow_in && !q.flush && !empty;

    // storage array, intentionally left unreset
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            mem_payload[wr_ptr] <= q.f_payload;
            mem_pc[wr_ptr]      <= q.f_pc;
            mem_rs1[wr_ptr]     <= q.f_rs1;
            mem_rs2[wr_ptr]     <= q.f_rs2;
            mem_use1[wr_ptr]    <= q.f_use_rs1;
            mem_use2[wr_ptr]    <= q.f_use_rs2;
            mem_commit[wr_ptr]  <= f_commit;
        end
    end

    // pointers, occupancy and saturating stall counter; flush empties the queue but keeps the stall count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            stall  <= '0;
        end else begin
            if (!empty && hazard && !q.flush && stall != 16'hFFFF) stall <= stall + 16'd1;
            if (q.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(enq);
                rd_ptr <= rd_ptr + AW'(deq);
                cnt    <= cnt + CW'(enq) - CW'(deq);
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue in its default (no bypass) build
module tb_decode_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    decode_queue_if #(.DATA_W(64), .DEPTH(4)) bus ();

    decode_queue #(.DATA_W(64), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .q  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [63:0] pl,
                         input logic [4:0] rs1, input logic u1);
        bus.f_to_d_valid = v;
        bus.f_pc         = pc;
        bus.f_payload    = pl;
        bus.f_rs1        = rs1;
        bus.f_use_rs1    = u1;
        bus.f_rs2        = 5'd0;
        bus.f_use_rs2    = 1'b0;
    endtask

    initial begin
        offer(1'b0, 32'h0, 64'h0, 5'd0, 1'b0);
        bus.e_allow_in = 1'b0;
        bus.e_valid    = 1'b0;
        bus.E_is_load  = 1'b0;
        bus.E_rd       = 5'd0;
        bus.flush      = 1'b0;
        tick();
        tick();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_valid", 64'(bus.d_to_e_valid), 64'd0);
        chk("rst_dpc", 64'(bus.D_pc), 64'd0);
        chk("rst_stall", 64'(bus.stall_cnt), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_allow", 64'(bus.d_allow_in), 64'd1);

        // fill: no bypass, so nothing is visible before the first enqueue lands
        offer(1'b1, 32'h80000000, 64'hA0, 5'd0, 1'b0);
        #1;
        chk("nobypass_valid", 64'(bus.d_to_e_valid), 64'd0);
        chk("nobypass_dpc", 64'(bus.D_pc), 64'd0);
        tick();
        chk("lat1_valid", 64'(bus.d_to_e_valid), 64'd1);
        for (int i = 1; i < 4; i++) begin
            offer(1'b1, 32'h80000000 + 32'(4 * i), 64'hA0 + 64'(i), 5'd0, 1'b0);
            tick();
        end
        chk("fill_count", 64'(bus.count), 64'd4);
        chk("fill_allow", 64'(bus.d_allow_in), 64'd0);
        offer(1'b1, 32'h80000010, 64'hFF, 5'd0, 1'b0);
        tick();
        chk("fill_fifth_count", 64'(bus.count), 64'd4);

        // drain in order
        offer(1'b0, 32'h0, 64'h0, 5'd0, 1'b0);
        bus.e_allow_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc", 64'(bus.D_pc), 64'h80000000 + 64'(4 * i));
            chk("drain_payload", bus.D_payload, 64'hA0 + 64'(i));
            chk("drain_commit", 64'(bus.D_commit), 64'd1);
            tick();
        end
        chk("drain_count", 64'(bus.count), 64'd0);
        chk("drain_valid", 64'(bus.d_to_e_valid), 64'd0);
        chk("drain_dpc", 64'(bus.D_pc), 64'd0);
        chk("drain_dpayload", bus.D_payload, 64'd0);
        chk("drain_commit0", 64'(bus.D_commit), 64'd0);

        // load-use hazard on rs1 for three cycles, execute ready but blocked
        bus.e_allow_in = 1'b0;
        offer(1'b1, 32'h80000100, 64'h55, 5'd5, 1'b1);
        tick();
        offer(1'b0, 32'h0, 64'h0, 5'd0, 1'b0);
        bus.e_valid    = 1'b1;
        bus.E_is_load  = 1'b1;
        bus.E_rd       = 5'd5;
        bus.e_allow_in = 1'b1;
        #1;
        chk("hazard_valid", 64'(bus.d_to_e_valid), 64'd0);
        tick();
        tick();
        tick();
        chk("hazard_stall", 64'(bus.stall_cnt), 64'd3);
        chk("hazard_count", 64'(bus.count), 64'd1);

        // x0 destination never creates a hazard
        bus.e_allow_in = 1'b0;
        bus.E_rd       = 5'd0;
        #1;
        chk("x0_valid", 64'(bus.d_to_e_valid), 64'd1);
        tick();
        chk("x0_stall", 64'(bus.stall_cnt), 64'd3);
        bus.e_valid    = 1'b0;
        bus.E_is_load  = 1'b0;
        bus.e_allow_in = 1'b1;
        tick();
        chk("x0_drain_count", 64'(bus.count), 64'd0);

        // flush with a concurrent enqueue
        bus.e_allow_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h00000200 + 32'(4 * i), 64'(i), 5'd0, 1'b0);
            tick();
        end
        chk("flush_pre_count", 64'(bus.count), 64'd3);
        offer(1'b1, 32'h0000020C, 64'h9, 5'd0, 1'b0);
        bus.flush      = 1'b1;
        bus.e_allow_in = 1'b1;
        tick();
        bus.flush = 1'b0;
        offer(1'b0, 32'h0, 64'h0, 5'd0, 1'b0);
        bus.e_allow_in = 1'b0;
        #1;
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.d_to_e_valid), 64'd0);
        chk("flush_stall_kept", 64'(bus.stall_cnt), 64'd3);

        // wrap: ten concurrent enqueue/dequeue pairs outside the commit window
        offer(1'b1, 32'h00001000, 64'h0, 5'd0, 1'b0);
        tick();
        bus.e_allow_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, 32'h00001000, 64'(i + 1), 5'd0, 1'b0);
            tick();
            chk("wrap_count", 64'(bus.count), 64'd1);
            chk("wrap_payload", bus.D_payload, 64'(i + 1));
        end
        chk("wrap_pc", 64'(bus.D_pc), 64'h1000);
        chk("wrap_commit", 64'(bus.D_commit), 64'd0);

        // full with a same-cycle dequeue still refuses the enqueue
        offer(1'b0, 32'h0, 64'h0, 5'd0, 1'b0);
        tick();
        bus.e_allow_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'h88000000 + 32'(4 * i), 64'h30 + 64'(i), 5'd0, 1'b0);
            tick();
        end
        chk("full_count", 64'(bus.count), 64'd4);
        chk("above_hi_commit", 64'(bus.D_commit), 64'd0);
        offer(1'b1, 32'h80000000, 64'h77, 5'd0, 1'b0);
        bus.e_allow_in = 1'b1;
        tick();
        chk("full_deq_count", 64'(bus.count), 64'd3);
        chk("full_deq_head", bus.D_payload, 64'h31);

        // reset mid-operation wins over enqueue
        rst = 1'b1;
        tick();
        chk("midrst_count", 64'(bus.count), 64'd0);
        chk("midrst_stall", 64'(bus.stall_cnt), 64'd0);
        chk("midrst_valid", 64'(bus.d_to_e_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning width of opaque decoded payload (opcode/funct/imm/prediction state).
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; power of two and at least 2.
REQ-003 SHALL have parameter COMMIT_LO, default 32'h80000000, meaning lowest PC that is flagged for commit.
REQ-004 SHALL have parameter COMMIT_HI, default 32'h87ffffff, meaning highest PC that is flagged for commit.
REQ-005 SHALL have port clk, input, 1 bit, the clock; reset is rst, synchronous, active-high.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port f_to_d_valid, input, 1 bit, meaning the fetch entry is valid.
REQ-008 SHALL have port d_allow_in, output, 1 bit, meaning the queue accepts an entry this cycle.
REQ-009 SHALL have ports f_payload (input, DATA_W), f_pc (input, 32), f_rs1/f_rs2 (input, 5 each) and f_use_rs1/f_use_rs2 (input, 1 each), meaning the entry fields.
REQ-010 SHALL have port e_allow_in, input, 1 bit, meaning execute accepts an entry.
REQ-011 SHALL have port d_to_e_valid, output, 1 bit, meaning the head is valid and hazard-free.
REQ-012 SHALL have ports D_payload (output, DATA_W), D_pc (output, 32), D_rs1/D_rs2 (output, 5 each) and D_commit (output, 1), meaning the head entry fields.
REQ-013 SHALL have ports e_valid (input, 1), E_is_load (input, 1) and E_rd (input, 5), meaning the execute-stage load for the hazard check.
REQ-014 SHALL have port flush, input, 1 bit, meaning a mispredict kill.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits, meaning the occupancy.
REQ-016 SHALL have port stall_cnt, output, 16 bits, meaning saturating load-use stall cycles.

Function
REQ-017 SHALL enqueue at the tail when f_to_d_valid && d_allow_in && !flush.
REQ-018 SHALL drive d_allow_in = (count != DEPTH), with no combinational dependence on e_allow_in.
REQ-019 SHALL compute hazard = e_valid && E_is_load && E_rd!=0 && ((head use_rs1 && E_rd==head rs1) || (head use_rs2 && E_rd==head rs2)).
REQ-020 SHALL drive d_to_e_valid = (count!=0) && !hazard.
REQ-021 SHALL dequeue the head when d_to_e_valid && e_allow_in && !flush.
REQ-022 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-023 SHALL wrap pointers modulo DEPTH.
REQ-024 SHALL, when count==0, drive all D_* outputs to 0.
REQ-025 SHALL set D_commit = (COMMIT_LO <= head pc <= COMMIT_HI), evaluated at enqueue and stored per entry.
REQ-026 SHALL give a minimum latency of 1 cycle from enqueue to d_to_e_valid, unless the configuration feature applies.
REQ-027 SHALL, on flush, set count and pointers to 0 next cycle and drop any same-cycle enqueue.
REQ-028 SHALL treat flush as a kill with no dequeue handshake.
REQ-029 SHALL increment stall_cnt when count!=0 && hazard && !flush, saturating at 16'hFFFF; flush does not clear stall_cnt.
REQ-030 SHALL never accept an enqueue when full, including when a dequeue occurs in the same cycle.

Reset
REQ-031 SHALL, while rst is high, set count=0, pointers=0, stall_cnt=0, d_to_e_valid=0 and all D_*=0.
REQ-032 SHALL make reset take priority over flush, enqueue and dequeue, including mid-operation.
REQ-033 SHALL NOT reset storage array contents.

Configuration
REQ-034 SHALL provide macro DECODE_QUEUE_BYPASS_EN.
REQ-035 SHALL, when DECODE_QUEUE_BYPASS_EN is defined, count==0, f_to_d_valid=1 and !flush, present f_* fields combinationally on D_*.
REQ-036 SHALL, in that bypass case, evaluate hazard on the f_* fields and drive d_to_e_valid from it.
REQ-037 SHALL, in that bypass case, not write the entry into storage if e_allow_in && d_to_e_valid.
REQ-038 SHALL, when DECODE_QUEUE_BYPASS_EN is undefined, have no bypass path and a latency of exactly 1 cycle or more.

Verification
REQ-039 SHALL cover fill: DEPTH=4, e_allow_in=0, four enqueues of pc 0x80000000..0x8000000C -> count=4, d_allow_in=0; fifth offer ignored.
REQ-040 SHALL cover drain order: from full, e_allow_in=1 -> D_pc sequence 0x80000000,4,8,C over 4 cycles, D_commit=1 each, then count=0 and D_*=0.
REQ-041 SHALL cover load-use: head rs1=5 with use_rs1=1, e_valid=1, E_is_load=1, E_rd=5 for 3 cycles -> d_to_e_valid=0 and stall_cnt=3.
REQ-042 SHALL cover x0: the same case with E_rd=0 -> d_to_e_valid=1 and stall_cnt unchanged.
REQ-043 SHALL cover flush: count=3, flush=1 with a concurrent enqueue -> count=0 next cycle, d_to_e_valid=0.
REQ-044 SHALL cover wrap and commit: 10 enqueue/dequeue pairs with pc 0x00001000 -> pointers wrap, data intact, D_commit=0, count stays 1.
